// File: rtl/byte_serializer.sv
// rtl/byte_serializer.sv - 32-bit word to byte stream serializer with valid/ready handshakes
// Zero-bubble back-to-back words: the last byte cycle can accept the next word.
module byte_serializer #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic [7:0]  words_sent
);
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  words_sent_q, words_sent_d;
  logic [1:0]  byte_sel;
  logic [7:0]  lane;
  logic        in_xfer, out_xfer;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      word_q       <= 32'h0;
      idx_q        <= 2'd0;
      words_sent_q <= 8'h00;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      idx_q        <= idx_d;
      words_sent_q <= words_sent_d;
    end
  end

  always_comb begin
    // Byte 0 is the top lane when MSB_FIRST, the bottom lane otherwise.
    byte_sel = MSB_FIRST ? (2'd3 - idx_q) : idx_q;
    case (byte_sel)
      2'd0:    lane = word_q[7:0];
      2'd1:    lane = word_q[15:8];
      2'd2:    lane = word_q[23:16];
      default: lane = word_q[31:24];
    endcase

    out_valid  = (state_q == SEND);
    out_last   = out_valid && (idx_q == 2'd3);
    out_data   = out_valid ? lane : 8'h00;
    in_ready   = !reset && ((state_q == IDLE) || (out_last && out_ready));
    words_sent = words_sent_q;

    in_xfer  = in_valid && in_ready;
    out_xfer = out_valid && out_ready;

    state_d      = state_q;
    word_d       = word_q;
    idx_d        = idx_q;
    words_sent_d = words_sent_q;

    case (state_q)
      IDLE: begin
        if (in_xfer) begin
          word_d  = in_data;
          idx_d   = 2'd0;
          state_d = SEND;
        end
      end
      default: begin
        if (out_xfer) begin
          if (idx_q == 2'd3) begin
            words_sent_d = words_sent_q + 8'd1;
            if (in_xfer) begin
              word_d = in_data;
              idx_d  = 2'd0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
    endcase
  end
endmodule

// File: tb/tb_byte_serializer.sv
// tb/tb_byte_serializer.sv - scoreboard bench for byte_serializer
// Two instances share stimulus: one MSB-first, one LSB-first.
module tb_byte_serializer;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        out_ready;
  logic        in_ready_m, out_valid_m, out_last_m;
  logic [7:0]  out_data_m, words_sent_m;
  logic        in_ready_l, out_valid_l, out_last_l;
  logic [7:0]  out_data_l, words_sent_l;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit acc;
  bit drv_timeout = 1'b0;
  // entry = {in_ready, out_last, out_data}
  logic [9:0] exp_m[$];
  logic [9:0] exp_l[$];
  logic [9:0] obs_m[$];
  logic [9:0] obs_l[$];
  int         obs_cyc[$];

  byte_serializer #(.MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_m),
    .out_data(out_data_m), .out_valid(out_valid_m), .out_ready(out_ready), .out_last(out_last_m),
    .words_sent(words_sent_m)
  );

  byte_serializer #(.MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_l),
    .out_data(out_data_l), .out_valid(out_valid_l), .out_ready(out_ready), .out_last(out_last_l),
    .words_sent(words_sent_l)
  );

  always #5 clk = ~clk;

  task automatic clear_q();
    exp_m.delete(); exp_l.delete(); obs_m.delete(); obs_l.delete(); obs_cyc.delete();
  endtask

  // One clock: sample handshakes at the falling edge, return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (!reset && in_valid && in_ready_m) begin
      acc = 1'b1;
      for (int k = 0; k < 4; k++) begin
        exp_m.push_back({k == 3, k == 3, in_data[31-8*k -: 8]});
        exp_l.push_back({k == 3, k == 3, in_data[8*k +: 8]});
      end
    end
    if (!reset && out_valid_m && out_ready) begin
      obs_m.push_back({in_ready_m, out_last_m, out_data_m});
      obs_l.push_back({in_ready_l, out_last_l, out_data_l});
      obs_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_word(input logic [31:0] w);
    in_data  = w;
    in_valid = 1'b1;
    acc      = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) tick();
    if (!acc) drv_timeout = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
    #2;
    n_cmp++; if ({out_valid_m, out_last_m, in_ready_m} !== 3'b000) begin n_err++;
      $display("FAIL reset_ctrl: {valid,last,in_ready}=%b want 000", {out_valid_m, out_last_m, in_ready_m}); end
    n_cmp++; if (out_data_m !== 8'h00) begin n_err++;
      $display("FAIL reset_data: got %h want 00", out_data_m); end
    n_cmp++; if (words_sent_m !== 8'h00) begin n_err++;
      $display("FAIL reset_count: got %0d want 0", words_sent_m); end
    @(posedge clk); #1; reset = 1'b0; #1;
    n_cmp++; if (in_ready_m !== 1'b1) begin n_err++;
      $display("FAIL reset_release_in_ready: got %b want 1", in_ready_m); end
  endtask

  task automatic test_single_and_order();
    clear_q(); out_ready = 1'b1;
    drive_word(32'h12345678);
    n_cmp++; if (out_valid_m !== 1'b1 || out_data_m !== 8'h12) begin n_err++;
      $display("FAIL single_latency: valid=%b data=%h want 1/12", out_valid_m, out_data_m); end
    for (int i = 0; i < 40 && out_valid_m; i++) tick();
    n_cmp++; if (out_valid_m !== 1'b0) begin n_err++;
      $display("FAIL single_idle: out_valid=%b want 0", out_valid_m); end
    n_cmp++; if (obs_m.size() != 4) begin n_err++;
      $display("FAIL single_count: bytes=%0d want 4", obs_m.size()); end
    for (int i = 0; i < exp_m.size() && i < obs_m.size(); i++) begin
      n_cmp++; if (obs_m[i] !== exp_m[i]) begin n_err++;
        $display("FAIL single_msb[%0d]: got %h want %h", i, obs_m[i], exp_m[i]); end
      n_cmp++; if (obs_l[i] !== exp_l[i]) begin n_err++;
        $display("FAIL order_lsb[%0d]: got %h want %h", i, obs_l[i], exp_l[i]); end
    end
    for (int i = 1; i < obs_cyc.size(); i++) begin
      n_cmp++; if (obs_cyc[i] !== obs_cyc[0] + i) begin n_err++;
        $display("FAIL single_gap[%0d]: cycle %0d want %0d", i, obs_cyc[i], obs_cyc[0] + i); end
    end
    n_cmp++; if (words_sent_m !== 8'd1 || words_sent_l !== 8'd1) begin n_err++;
      $display("FAIL single_words: got %0d/%0d want 1", words_sent_m, words_sent_l); end
  endtask

  task automatic test_backpressure();
    clear_q(); out_ready = 1'b1;
    drive_word(32'h12345678);
    in_data = 32'hDEADBEEF;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (out_valid_m !== 1'b1 || out_data_m !== 8'h34) begin n_err++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%h want 1/34", i, out_valid_m, out_data_m); end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 40 && out_valid_m; i++) tick();
    n_cmp++; if (obs_m.size() != 4) begin n_err++;
      $display("FAIL bp_count: bytes=%0d want 4", obs_m.size()); end
    for (int i = 0; i < exp_m.size() && i < obs_m.size(); i++) begin
      n_cmp++; if (obs_m[i] !== exp_m[i]) begin n_err++;
        $display("FAIL bp_byte[%0d]: got %h want %h", i, obs_m[i], exp_m[i]); end
    end
    n_cmp++; if (words_sent_m !== 8'd2) begin n_err++;
      $display("FAIL bp_words: got %0d want 2", words_sent_m); end
  endtask

  task automatic test_back_to_back();
    clear_q(); out_ready = 1'b1;
    drive_word(32'hAABBCCDD);
    drive_word(32'h01020304);
    for (int i = 0; i < 40 && out_valid_m; i++) tick();
    n_cmp++; if (obs_m.size() != 8) begin n_err++;
      $display("FAIL b2b_count: bytes=%0d want 8", obs_m.size()); end
    for (int i = 0; i < exp_m.size() && i < obs_m.size(); i++) begin
      n_cmp++; if (obs_m[i] !== exp_m[i]) begin n_err++;
        $display("FAIL b2b_byte[%0d]: got %h want %h", i, obs_m[i], exp_m[i]); end
    end
    for (int i = 1; i < obs_cyc.size(); i++) begin
      n_cmp++; if (obs_cyc[i] !== obs_cyc[0] + i) begin n_err++;
        $display("FAIL b2b_gap[%0d]: cycle %0d want %0d", i, obs_cyc[i], obs_cyc[0] + i); end
    end
    n_cmp++; if (words_sent_m !== 8'd4) begin n_err++;
      $display("FAIL b2b_words: got %0d want 4", words_sent_m); end
  endtask

  task automatic test_reset_mid();
    clear_q(); out_ready = 1'b1;
    drive_word(32'h12345678);
    tick();
    tick();
    reset = 1'b1;
    #1;
    n_cmp++; if (out_valid_m !== 1'b0 || out_last_m !== 1'b0) begin n_err++;
      $display("FAIL mid_reset_valid: valid=%b last=%b want 0/0", out_valid_m, out_last_m); end
    n_cmp++; if (words_sent_m !== 8'd0 || in_ready_m !== 1'b0) begin n_err++;
      $display("FAIL mid_reset_state: words=%0d in_ready=%b want 0/0", words_sent_m, in_ready_m); end
    n_cmp++; if (obs_m.size() != 2) begin n_err++;
      $display("FAIL mid_partial_count: bytes=%0d want 2", obs_m.size()); end
    for (int i = 0; i < 2 && i < obs_m.size(); i++) begin
      n_cmp++; if (obs_m[i] !== exp_m[i]) begin n_err++;
        $display("FAIL mid_partial[%0d]: got %h want %h", i, obs_m[i], exp_m[i]); end
    end
    clear_q();
    tick();
    reset = 1'b0;
    drive_word(32'h12345678);
    for (int i = 0; i < 40 && out_valid_m; i++) tick();
    n_cmp++; if (obs_m.size() != 4) begin n_err++;
      $display("FAIL mid_after_count: bytes=%0d want 4", obs_m.size()); end
    for (int i = 0; i < exp_m.size() && i < obs_m.size(); i++) begin
      n_cmp++; if (obs_m[i] !== exp_m[i]) begin n_err++;
        $display("FAIL mid_after[%0d]: got %h want %h", i, obs_m[i], exp_m[i]); end
    end
    n_cmp++; if (words_sent_m !== 8'd1) begin n_err++;
      $display("FAIL mid_words: got %0d want 1", words_sent_m); end
  endtask

  task automatic test_wrap();
    reset = 1'b1; tick(); reset = 1'b0;
    clear_q(); out_ready = 1'b1;
    for (int w = 0; w < 255; w++) drive_word($urandom);
    for (int i = 0; i < 40 && out_valid_m; i++) tick();
    n_cmp++; if (words_sent_m !== 8'd255) begin n_err++;
      $display("FAIL wrap_255: got %0d want 255", words_sent_m); end
    n_cmp++; if (obs_m.size() != exp_m.size()) begin n_err++;
      $display("FAIL wrap_count: bytes=%0d want %0d", obs_m.size(), exp_m.size()); end
    for (int i = 0; i < exp_m.size() && i < obs_m.size(); i++) begin
      n_cmp++; if (obs_m[i] !== exp_m[i] || obs_l[i] !== exp_l[i]) begin n_err++;
        $display("FAIL wrap_byte[%0d]: got %h/%h want %h/%h", i, obs_m[i], obs_l[i], exp_m[i], exp_l[i]); end
    end
    clear_q();
    drive_word(32'hCAFEF00D);
    for (int i = 0; i < 40 && out_valid_m; i++) tick();
    n_cmp++; if (words_sent_m !== 8'd0 || words_sent_l !== 8'd0) begin n_err++;
      $display("FAIL wrap_zero: got %0d/%0d want 0", words_sent_m, words_sent_l); end
  endtask

  initial begin
    test_reset();
    test_single_and_order();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    n_cmp++; if (drv_timeout) begin n_err++;
      $display("FAIL input_accept_timeout: timeout=%b want 0", drv_timeout); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
